slicer_err_gen: RTL and testbench
=================================

SLICER_ERR_GEN -- requirements
Module: slicer_err_gen

Interface
REQ-001 SHALL have parameter LFSR_WID, default 22, meaning measurement-window LFSR width; window = 2^LFSR_WID-1 symbols; legal 4..24.
REQ-002 SHALL have port sys_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sym_clk_en  input  1  one-sys_clk-wide symbol strobe.
REQ-005 SHALL have port sample_in  input  18 signed 2s16  received symbol sample.
REQ-006 SHALL have port ref_a  input  18 signed 2s16  inner 4-ASK level a (outer level 3a).
REQ-007 SHALL have port dc_est  input  18 signed 2s16  DC estimate from downstream avg_err block.
REQ-008 SHALL have port dec_sym  output  2  decision: 00=-3a, 01=-a, 10=+a, 11=+3a.
REQ-009 SHALL have port error  output  18 signed 2s16  sample minus decided level.
REQ-010 SHALL have port clr_acc  output  1  window-boundary level for downstream accumulators.

Function
REQ-011 SHALL form x = sample_in (or x = sat18(sample_in - dc_est) per REQ-024), internal width 20 bits.
REQ-012 SHALL slice: x>=2a -> 11; 0<=x<2a -> 10; -2a<=x<0 -> 01; x<-2a -> 00; comparisons exact, ties go to the upper region.
REQ-013 SHALL compute error = x - level(dec_sym) in 20 bits, saturated to [-131072, 131071].
REQ-014 SHALL, when ref_a <= 0, force dec_sym = 10 and error = x.
REQ-015 SHALL register dec_sym and error only on sys_clk edges with sym_clk_en=1; latency 1 sys_clk; outputs hold otherwise.
REQ-016 SHALL advance a maximal-length Fibonacci LFSR once per sym_clk_en; seed all-ones.
REQ-017 SHALL set clr_acc=1 on the sym_clk_en edge at which the LFSR returns to the seed, and clear it on the next sym_clk_en edge; high exactly one symbol period per window.
REQ-018 SHALL keep clr_acc period = 2^LFSR_WID-1 symbols, wrap-around seamless, no gap symbols.
REQ-019 SHALL ignore sym_clk_en while reset_n=0.

Reset
REQ-020 SHALL, on reset_n=0, asynchronously set dec_sym=10, error=0, clr_acc=0, LFSR=seed.
REQ-021 SHALL, on reset mid-window, restart the window; first clr_acc after 2^LFSR_WID-1 sym_clk_en pulses following release.
REQ-022 SHALL not produce a clr_acc pulse as a side effect of reset assertion or release.

Configuration
REQ-023 SHALL use macro SLICER_DC_CORR_EN.
REQ-024 SHALL, with SLICER_DC_CORR_EN defined, slice x = sat18(sample_in - dc_est); without it, x = sample_in, dc_est ignored (unloaded).

Structure
REQ-025 SHALL place in a shared package: 2s16 width constants, dec_sym encodings, LFSR tap table per width 4..24, seed constant.
REQ-026 SHALL implement the LFSR as sub-module lfsr_win (parameter LFSR_WID; ports sys_clk, reset_n, adv, state, at_seed).

Verification
REQ-027 SHALL cover: ref_a=8192, sample_in=19661, strobe -> next cycle dec_sym=11, error=-4915.
REQ-028 SHALL cover: ref_a=8192, sample_in=16384 then -16384 -> dec_sym=11 error=-8192, then dec_sym=01 error=-8192.
REQ-029 SHALL cover: LFSR_WID=4, continuous strobes -> clr_acc high one symbol every 15 symbols, first rise at 15th strobe.
REQ-030 SHALL cover: reset_n low at symbol 7 of a window (LFSR_WID=4) -> outputs to reset values immediately; next clr_acc 15 strobes after release.
REQ-031 SHALL cover: SLICER_DC_CORR_EN defined, dc_est=-131072, sample_in=131071, ref_a=8192 -> x=131071, dec_sym=11, error=106495; macro undefined -> identical result with dc_est ignored.
REQ-032 SHALL cover: ref_a=0, sample_in=-5000 -> dec_sym=10, error=-5000.

Source files
------------

// File: rtl/slicer_err_gen_pkg.sv
// slicer_err_gen_pkg: shared widths, decision encodings, saturation helper and LFSR tap table
// for the 4-ASK slicer.
package slicer_err_gen_pkg;
    localparam int DW = 18;
    localparam int IW = 20;
    localparam logic signed [DW-1:0] MAX18 = 18'sh1ffff;
    localparam logic signed [DW-1:0] MIN18 = 18'sh20000;
    typedef enum logic [1:0] {
        SYM_M3 = 2'b00,
        SYM_M1 = 2'b01,
        SYM_P1 = 2'b10,
        SYM_P3 = 2'b11
    } sym_t;
    localparam logic [23:0] LFSR_SEED = 24'hffffff;
    // Maximal-length feedback taps, bit t-1 set for tap position t.
    function automatic logic [23:0] lfsr_taps(input int w);
        case (w)
            4:       return 24'h00000c;
            5:       return 24'h000014;
            6:       return 24'h000030;
            7:       return 24'h000060;
            8:       return 24'h0000b8;
            9:       return 24'h000110;
            10:      return 24'h000240;
            11:      return 24'h000500;
            12:      return 24'h000829;
            13:      return 24'h00100d;
            14:      return 24'h002015;
            15:      return 24'h006000;
            16:      return 24'h00d008;
            17:      return 24'h012000;
            18:      return 24'h020400;
            19:      return 24'h040023;
            20:      return 24'h090000;
            21:      return 24'h140000;
            22:      return 24'h300000;
            23:      return 24'h420000;
            default: return 24'he10000;
        endcase
    endfunction
    function automatic logic signed [DW-1:0] sat18(input logic signed [IW-1:0] v);
        return v > 20'sd131071 ? MAX18 : v < -20'sd131072 ? MIN18 : v[DW-1:0];
    endfunction
endpackage

// File: rtl/slicer_err_gen_lfsr_win.sv
// lfsr_win: Fibonacci LFSR measurement-window timer, seeded all-ones; at_seed flags that the
// next advance returns the register to the seed.
module lfsr_win
    import slicer_err_gen_pkg::*;
#(
    parameter int LFSR_WID = 22
) (
    input  logic                sys_clk,
    input  logic                reset_n,
    input  logic                adv,
    output logic [LFSR_WID-1:0] state,
    output logic                at_seed
);
    localparam logic [23:0] TAPS_ALL = lfsr_taps(LFSR_WID);
    localparam logic [LFSR_WID-1:0] TAPS = TAPS_ALL[LFSR_WID-1:0];
    localparam logic [LFSR_WID-1:0] SEED = LFSR_SEED[LFSR_WID-1:0];
    logic [LFSR_WID-1:0] nxt;
    assign nxt = {state[LFSR_WID-2:0], ^(state & TAPS)};
    assign at_seed = nxt == SEED;
    always_ff @(posedge sys_clk or negedge reset_n)
        if (!reset_n)
            state <= SEED;
        else if (adv)
            state <= nxt;
endmodule

// File: rtl/slicer_err_gen.sv
// slicer_err_gen: 4-ASK slicer with registered decision/error and an LFSR-timed window pulse.
// Define SLICER_DC_CORR_EN to subtract dc_est from the sample before slicing.
module slicer_err_gen
    import slicer_err_gen_pkg::*;
#(
    parameter int LFSR_WID = 22
) (
    input  logic               sys_clk,
    input  logic               reset_n,
    input  logic               sym_clk_en,
    input  logic signed [17:0] sample_in,
    input  logic signed [17:0] ref_a,
    input  logic signed [17:0] dc_est,
    output logic [1:0]         dec_sym,
    output logic signed [17:0] error,
    output logic               clr_acc
);
    logic signed [IW-1:0] x, a1, a2, a3, lvl;
    logic                 bad_ref, at_seed;
    logic [LFSR_WID-1:0]  unused_state;
    sym_t                 sym;
`ifdef SLICER_DC_CORR_EN
    assign x = IW'(sat18(IW'(sample_in) - IW'(dc_est)));
`else
    logic unused_dc;
    assign unused_dc = ^dc_est;
    assign x = IW'(sample_in);
`endif
    assign a1 = IW'(ref_a);
    assign a2 = a1 <<< 1;
    assign a3 = a2 + a1;
    assign bad_ref = ref_a <= 18'sd0;
    // Ties land in the upper region because every threshold test is >=.
    assign sym = bad_ref ? SYM_P1 : x >= a2 ? SYM_P3 : x >= 20'sd0 ? SYM_P1 : x >= -a2 ? SYM_M1 : SYM_M3;
    assign lvl = bad_ref ? '0 : sym == SYM_P3 ? a3 : sym == SYM_P1 ? a1 : sym == SYM_M1 ? -a1 : -a3;
    always_ff @(posedge sys_clk or negedge reset_n)
        if (!reset_n) begin
            dec_sym <= SYM_P1;
            error   <= '0;
            clr_acc <= 1'b0;
        end else if (sym_clk_en) begin
            dec_sym <= sym;
            error   <= sat18(x - lvl);
            clr_acc <= at_seed;
        end
    lfsr_win #(.LFSR_WID(LFSR_WID)) u_win (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .adv     (sym_clk_en),
        .state   (unused_state),
        .at_seed (at_seed)
    );
endmodule

// File: tb/tb_slicer_err_gen.sv
// tb_slicer_err_gen: table vectors, reset/window sequences and randomized traffic against an
// arithmetic reference model of slicer_err_gen (LFSR_WID=4, 15-symbol window).
module tb_slicer_err_gen;
    localparam int W = 4;
    localparam int PER = (1 << W) - 1;
`ifdef SLICER_DC_CORR_EN
    localparam int DC_ON = 1;
`else
    localparam int DC_ON = 0;
`endif
    typedef struct {
        string name;
        int s, ra, dc, sym, err;
    } vec_t;
    logic sys_clk = 1'b0, reset_n = 1'b1, sym_clk_en = 1'b0;
    logic signed [17:0] sample_in = '0, ref_a = '0, dc_est = '0, error;
    logic [1:0] dec_sym;
    logic clr_acc;
    int n_chk = 0, n_fail = 0, cnt = 0, exp_sym = 2, exp_err = 0;
    vec_t v[10];

    slicer_err_gen #(.LFSR_WID(W)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .sym_clk_en (sym_clk_en),
        .sample_in  (sample_in),
        .ref_a      (ref_a),
        .dc_est     (dc_est),
        .dec_sym    (dec_sym),
        .error      (error),
        .clr_acc    (clr_acc)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int clamp(input int val);
        return val > 131071 ? 131071 : val < -131072 ? -131072 : val;
    endfunction

    function automatic void model(input int s, input int ra, input int dc, output int sym, output int err);
        int x, lvl;
        x = clamp(s - dc * DC_ON);
        if (ra <= 0) begin
            sym = 2;
            lvl = 0;
        end else if (x >= 2 * ra) begin
            sym = 3;
            lvl = 3 * ra;
        end else if (x >= 0) begin
            sym = 2;
            lvl = ra;
        end else if (x >= -2 * ra) begin
            sym = 1;
            lvl = -ra;
        end else begin
            sym = 0;
            lvl = -3 * ra;
        end
        err = clamp(x - lvl);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        check({tag, ".dec"}, int'(dec_sym), exp_sym);
        check({tag, ".err"}, int'(error), exp_err);
        check({tag, ".clr"}, int'(clr_acc), (cnt > 0 && cnt % PER == 0) ? 1 : 0);
    endtask

    task automatic cyc(input logic en);
        sym_clk_en = en;
        @(posedge sys_clk);
        #1;
        if (en && reset_n) begin
            cnt++;
            model(int'(sample_in), int'(ref_a), int'(dc_est), exp_sym, exp_err);
        end
        @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        v[0] = '{"r27",    19661,   8192,       0, 3,  -4915};
        v[1] = '{"tie2a",  16384,   8192,       0, 3,  -8192};
        v[2] = '{"tiem2a", -16384,  8192,       0, 1,  -8192};
        v[3] = '{"dcsat",  131071,  8192, -131072, 3, 106495};
        v[4] = '{"aZero",  -5000,   0,          0, 2,  -5000};
        v[5] = '{"xZero",  0,       8192,       0, 2,  -8192};
        v[6] = '{"xNeg1",  -1,      8192,       0, 1,   8191};
        v[7] = '{"below",  -16385,  8192,       0, 0,   8191};
        v[8] = '{"aNeg",   777,     -100,       0, 2,    777};
        v[9] = '{"bigA",   131071,  131071,     0, 2,      0};
        #1 reset_n = 1'b0;
        #1 chk_all("reset0");
        @(negedge sys_clk);
        repeat (2) begin
            sample_in = 18'sd20000;
            ref_a = 18'sd8192;
            cyc(1'b1);
            chk_all("inreset");
        end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sample_in = 18'(v[i].s);
            ref_a = 18'(v[i].ra);
            dc_est = 18'(v[i].dc);
            cyc(1'b1);
            check({v[i].name, ".dec"}, int'(dec_sym), v[i].sym);
            check({v[i].name, ".err"}, int'(error), v[i].err);
            check({v[i].name, ".clr"}, int'(clr_acc), (cnt % PER == 0) ? 1 : 0);
            sample_in = 18'($urandom);
            cyc(1'b0);
            check({v[i].name, ".hold_dec"}, int'(dec_sym), v[i].sym);
            check({v[i].name, ".hold_err"}, int'(error), v[i].err);
        end
        ref_a = 18'sd8192;
        dc_est = '0;
        while (cnt % PER != 7) begin
            sample_in = 18'($urandom);
            cyc(1'b1);
            chk_all("pre");
        end
        #2 reset_n = 1'b0;
        #1;
        cnt = 0;
        exp_sym = 2;
        exp_err = 0;
        chk_all("midrst");
        repeat (2) begin
            cyc(1'b1);
            chk_all("midhold");
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 2 * PER + 2; i++) begin
            sample_in = 18'($urandom);
            cyc(1'b1);
            check("win.clr", int'(clr_acc), (i == PER || i == 2 * PER) ? 1 : 0);
            chk_all("win");
        end
        repeat (400) begin
            sample_in = 18'($urandom);
            ref_a = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 42000) - 2000);
            dc_est = 18'($urandom);
            cyc($urandom_range(0, 3) != 0);
            chk_all("rand");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
